// File: rtl/wf_tx_frame_buffer_pkg.sv
// Shared constants, state encoding and header helper for the wireless TX frame buffer.
package wf_pkg;

    localparam logic [7:0] ASCII_EOT       = 8'h04;
    localparam logic [7:0] DEF_MAC_ADDR    = 8'h42;
    localparam logic [7:0] DEF_TYPE_BYTE   = 8'h30;
    localparam int         DEF_MAX_PAYLOAD = 252;
    localparam int         HEADER_LEN      = 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD,
        SEND
    } wfState_e;

    // Header bytes are synthesised on the fly, never stored in the payload RAM.
    function automatic logic [7:0] headerByte(input logic [7:0] idx,
                                              input logic [7:0] dest,
                                              input logic [7:0] mac,
                                              input logic [7:0] typ);
        logic [7:0] result;
        case (idx)
            8'd0:    result = dest;
            8'd1:    result = mac;
            default: result = typ;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/wf_tx_frame_buffer_if.sv
// Byte-stream bundle between the UART receiver, the frame buffer and the Manchester transmitter.
interface wf_tx_frame_buffer_if;
    import wf_pkg::*;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic       tx_rdy;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_rd;
    logic [7:0] pay_len;
    logic       overflow;

    modport master (
        output rx_data, rx_valid, rx_ferr, tx_rd,
        input  tx_rdy, tx_data, tx_last, pay_len, overflow
    );

    modport slave (
        input  rx_data, rx_valid, rx_ferr, tx_rd,
        output tx_rdy, tx_data, tx_last, pay_len, overflow
    );

endinterface

// File: rtl/wf_tx_frame_buffer_ram.sv
// 256x8 simple dual-port payload store: synchronous write, one-cycle registered read.
module wf_frame_ram
    import wf_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [256];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/wf_tx_frame_buffer.sv
// Collects one UART frame (dest + payload up to EOT), then streams dest/MAC/type/payload
// out through a registered show-ahead byte port.
module wf_tx_frame_buffer
    import wf_pkg::*;
#(
    parameter logic [7:0] MAC_ADDR    = DEF_MAC_ADDR,
    parameter int         MAX_PAYLOAD = DEF_MAX_PAYLOAD,
    parameter logic [7:0] TYPE_BYTE   = DEF_TYPE_BYTE
) (
    input  logic                 clk,
    input  logic                 rst,
    wf_tx_frame_buffer_if.slave  bus
);

    localparam logic [7:0] LastFillLen = 8'(MAX_PAYLOAD - 1);
    localparam logic [7:0] HdrLastIdx  = 8'(HEADER_LEN - 1);
    localparam logic [7:0] HdrLen      = 8'(HEADER_LEN);

    wfState_e   state_q, state_d;
    logic [7:0] payLen_q, payLen_d;
    logic [7:0] dest_q, dest_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] txData_q, txData_d;
    logic       txRdy_q, txRdy_d;
    logic       txLast_q, txLast_d;
    logic       overflow_q, overflow_d;

    logic       ramWe;
    logic [7:0] ramRaddr;
    logic [7:0] ramRdata;
    logic       rxGood;
    logic       rxEot;
    logic       popReq;
    logic [7:0] nextIdx;
    logic [7:0] lastIdx;

    assign rxGood  = bus.rx_valid & ~bus.rx_ferr;
    assign rxEot   = (bus.rx_data == ASCII_EOT);
    assign popReq  = bus.tx_rd & txRdy_q;
    assign nextIdx = idx_q + 8'd1;
    assign lastIdx = payLen_q + HdrLastIdx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (rxGood && !rxEot) state_d = FILL;
            FILL: if (rxGood && (rxEot || payLen_q == LastFillLen)) state_d = HOLD;
            HOLD: state_d = SEND;
            SEND: if (popReq && txLast_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        payLen_d   = payLen_q;
        dest_d     = dest_q;
        idx_d      = idx_q;
        txData_d   = txData_q;
        txRdy_d    = txRdy_q;
        txLast_d   = txLast_q;
        overflow_d = overflow_q;
        ramWe      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rxGood && !rxEot) begin
                    dest_d   = bus.rx_data;
                    payLen_d = 8'd0;
                end
            end
            FILL: begin
                if (rxGood && !rxEot) begin
                    ramWe    = 1'b1;
                    payLen_d = payLen_q + 8'd1;
                end
            end
            HOLD: begin
                overflow_d = overflow_q | rxGood;
                txRdy_d    = 1'b1;
                txData_d   = dest_q;
                txLast_d   = 1'b0;
                idx_d      = 8'd0;
            end
            SEND: begin
                overflow_d = overflow_q | rxGood;
                if (popReq) begin
                    if (txLast_q) begin
                        txRdy_d  = 1'b0;
                        txLast_d = 1'b0;
                        txData_d = 8'h00;
                        payLen_d = 8'd0;
                        idx_d    = 8'd0;
                    end else begin
                        idx_d    = nextIdx;
                        txData_d = (nextIdx < HdrLen)
                                 ? headerByte(nextIdx, dest_q, MAC_ADDR, TYPE_BYTE)
                                 : ramRdata;
                        txLast_d = (nextIdx == lastIdx);
                    end
                end
            end
            default: ;
        endcase
        // The RAM output must already hold the byte after the one being presented.
        ramRaddr = (idx_d >= HdrLastIdx) ? (idx_d - HdrLastIdx) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            payLen_q   <= 8'd0;
            dest_q     <= 8'd0;
            idx_q      <= 8'd0;
            txData_q   <= 8'h00;
            txRdy_q    <= 1'b0;
            txLast_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            payLen_q   <= payLen_d;
            dest_q     <= dest_d;
            idx_q      <= idx_d;
            txData_q   <= txData_d;
            txRdy_q    <= txRdy_d;
            txLast_q   <= txLast_d;
            overflow_q <= overflow_d;
        end
    end

    wf_frame_ram u_ram (
        .clk   (clk),
        .we    (ramWe),
        .waddr (payLen_q),
        .wdata (bus.rx_data),
        .raddr (ramRaddr),
        .rdata (ramRdata)
    );

    assign bus.tx_rdy   = txRdy_q;
    assign bus.tx_data  = txData_q;
    assign bus.tx_last  = txLast_q;
    assign bus.pay_len  = payLen_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_wf_tx_frame_buffer.sv
// Directed self-checking bench for wf_tx_frame_buffer: frame assembly, commit, streaming and error paths.
module tb_wf_tx_frame_buffer;
    import wf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    wf_tx_frame_buffer_if bus();

    wf_tx_frame_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int         checkCount = 0;
    int         failCount  = 0;
    logic [7:0] gotData [300];
    logic       gotLast [300];
    int         gotCnt;
    logic [7:0] expData [256];
    int         expLen;

    task automatic applyStimulus(input logic [7:0] d, input logic ferr);
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        bus.rx_ferr  = ferr;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.rx_ferr  = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic waitReady(input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            if (bus.tx_rdy) ok = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
    endtask

    // Pops until tx_last is seen, tx_rdy drops, or maxBytes pops have been issued.
    task automatic popFrame(input int maxBytes);
        bit done = 1'b0;
        gotCnt = 0;
        while (!done && gotCnt < maxBytes && bus.tx_rdy) begin
            gotData[gotCnt] = bus.tx_data;
            gotLast[gotCnt] = bus.tx_last;
            gotCnt++;
            bus.tx_rd = 1'b1;
            @(posedge clk); #1;
            bus.tx_rd = 1'b0;
            if (gotLast[gotCnt-1]) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if (bus.tx_rdy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_tx_rdy: got %b expected 0", bus.tx_rdy); end
        checkCount++;
        if (bus.tx_last !== 1'b0) begin failCount++; $display("[TB] FAIL reset_tx_last: got %b expected 0", bus.tx_last); end
        checkCount++;
        if (bus.tx_data !== 8'h00) begin failCount++; $display("[TB] FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
        checkCount++;
        if (bus.pay_len !== 8'd0) begin failCount++; $display("[TB] FAIL reset_pay_len: got %0d expected 0", bus.pay_len); end
        checkCount++;
        if (bus.overflow !== 1'b0) begin failCount++; $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow); end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] pay [5] = '{8'h19, 8'hE1, 8'h2F, 8'h4B, 8'h04};
        doReset();
        applyStimulus(8'h44, 1'b0);
        foreach (pay[i]) applyStimulus(pay[i], 1'b0);
        waitReady(20, ok);
        checkCount++;
        if (!ok) begin failCount++; $display("[TB] FAIL basic_ready: got tx_rdy=0 expected 1"); end
        checkCount++;
        if (bus.pay_len !== 8'd4) begin failCount++; $display("[TB] FAIL basic_pay_len: got %0d expected 4", bus.pay_len); end
        expData[0:6] = '{8'h44, 8'h42, 8'h30, 8'h19, 8'hE1, 8'h2F, 8'h4B};
        expLen = 7;
        popFrame(20);
        checkCount++;
        if (gotCnt !== expLen) begin failCount++; $display("[TB] FAIL basic_len: got %0d expected %0d", gotCnt, expLen); end
        for (int i = 0; i < gotCnt && i < expLen; i++) begin
            checkCount++;
            if (gotData[i] !== expData[i] || gotLast[i] !== (i == expLen - 1))
                begin failCount++; $display("[TB] FAIL basic_byte%0d: got %h last=%b expected %h last=%b", i, gotData[i], gotLast[i], expData[i], (i == expLen - 1)); end
        end
        checkCount++;
        if (bus.tx_rdy !== 1'b0 || bus.pay_len !== 8'd0)
            begin failCount++; $display("[TB] FAIL basic_after: got tx_rdy=%b pay_len=%0d expected 0/0", bus.tx_rdy, bus.pay_len); end
    endtask

    task automatic test_zero_payload();
        bit ok;
        doReset();
        applyStimulus(8'h66, 1'b0);
        applyStimulus(8'h04, 1'b0);
        waitReady(20, ok);
        checkCount++;
        if (!ok || bus.pay_len !== 8'd0)
            begin failCount++; $display("[TB] FAIL zero_ready: got rdy=%b pay_len=%0d expected 1/0", ok, bus.pay_len); end
        expData[0:2] = '{8'h66, 8'h42, 8'h30};
        expLen = 3;
        popFrame(10);
        checkCount++;
        if (gotCnt !== expLen) begin failCount++; $display("[TB] FAIL zero_len: got %0d expected %0d", gotCnt, expLen); end
        for (int i = 0; i < gotCnt && i < expLen; i++) begin
            checkCount++;
            if (gotData[i] !== expData[i] || gotLast[i] !== (i == expLen - 1))
                begin failCount++; $display("[TB] FAIL zero_byte%0d: got %h last=%b expected %h last=%b", i, gotData[i], gotLast[i], expData[i], (i == expLen - 1)); end
        end
    endtask

    task automatic test_ferr();
        bit ok;
        doReset();
        applyStimulus(8'h44, 1'b0);
        applyStimulus(8'h19, 1'b0);
        applyStimulus(8'hE1, 1'b1);
        applyStimulus(8'h2F, 1'b0);
        applyStimulus(8'h04, 1'b0);
        waitReady(20, ok);
        checkCount++;
        if (!ok) begin failCount++; $display("[TB] FAIL ferr_ready: got tx_rdy=0 expected 1"); end
        expData[0:4] = '{8'h44, 8'h42, 8'h30, 8'h19, 8'h2F};
        expLen = 5;
        popFrame(10);
        checkCount++;
        if (gotCnt !== expLen) begin failCount++; $display("[TB] FAIL ferr_len: got %0d expected %0d", gotCnt, expLen); end
        for (int i = 0; i < gotCnt && i < expLen; i++) begin
            checkCount++;
            if (gotData[i] !== expData[i] || gotLast[i] !== (i == expLen - 1))
                begin failCount++; $display("[TB] FAIL ferr_byte%0d: got %h last=%b expected %h last=%b", i, gotData[i], gotLast[i], expData[i], (i == expLen - 1)); end
        end
        checkCount++;
        if (bus.overflow !== 1'b0) begin failCount++; $display("[TB] FAIL ferr_overflow: got %b expected 0", bus.overflow); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        doReset();
        applyStimulus(8'h44, 1'b0);
        applyStimulus(8'h19, 1'b0);
        applyStimulus(8'hE1, 1'b0);
        checkCount++;
        if (bus.pay_len !== 8'd2) begin failCount++; $display("[TB] FAIL mid_fill_len: got %0d expected 2", bus.pay_len); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checkCount++;
        if (bus.pay_len !== 8'd0 || bus.tx_rdy !== 1'b0)
            begin failCount++; $display("[TB] FAIL mid_reset: got pay_len=%0d tx_rdy=%b expected 0/0", bus.pay_len, bus.tx_rdy); end
        // A lone EOT in IDLE must not open a frame, so 55 still becomes the destination.
        applyStimulus(8'h04, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkCount++;
        if (bus.tx_rdy !== 1'b0) begin failCount++; $display("[TB] FAIL idle_eot: got tx_rdy=%b expected 0", bus.tx_rdy); end
        applyStimulus(8'h55, 1'b0);
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'h04, 1'b0);
        waitReady(20, ok);
        checkCount++;
        if (!ok) begin failCount++; $display("[TB] FAIL mid_ready: got tx_rdy=0 expected 1"); end
        expData[0:3] = '{8'h55, 8'h42, 8'h30, 8'hAA};
        expLen = 4;
        popFrame(10);
        checkCount++;
        if (gotCnt !== expLen) begin failCount++; $display("[TB] FAIL mid_len: got %0d expected %0d", gotCnt, expLen); end
        for (int i = 0; i < gotCnt && i < expLen; i++) begin
            checkCount++;
            if (gotData[i] !== expData[i] || gotLast[i] !== (i == expLen - 1))
                begin failCount++; $display("[TB] FAIL mid_byte%0d: got %h last=%b expected %h last=%b", i, gotData[i], gotLast[i], expData[i], (i == expLen - 1)); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit stable = 1'b1;
        logic [7:0] snapData;
        logic snapLast;
        doReset();
        applyStimulus(8'h21, 1'b0);
        bus.tx_rd = 1'b1;
        applyStimulus(8'h7A, 1'b0);
        bus.tx_rd = 1'b0;
        applyStimulus(8'h04, 1'b0);
        waitReady(20, ok);
        checkCount++;
        if (!ok) begin failCount++; $display("[TB] FAIL stall_ready: got tx_rdy=0 expected 1"); end
        snapData = bus.tx_data;
        snapLast = bus.tx_last;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (bus.tx_data !== snapData || bus.tx_last !== snapLast || bus.tx_rdy !== 1'b1) stable = 1'b0;
        end
        checkCount++;
        if (!stable) begin failCount++; $display("[TB] FAIL stall_stable: got changing outputs expected stable"); end
        expData[0:3] = '{8'h21, 8'h42, 8'h30, 8'h7A};
        expLen = 4;
        popFrame(10);
        checkCount++;
        if (gotCnt !== expLen) begin failCount++; $display("[TB] FAIL stall_len: got %0d expected %0d", gotCnt, expLen); end
        for (int i = 0; i < gotCnt && i < expLen; i++) begin
            checkCount++;
            if (gotData[i] !== expData[i] || gotLast[i] !== (i == expLen - 1))
                begin failCount++; $display("[TB] FAIL stall_byte%0d: got %h last=%b expected %h last=%b", i, gotData[i], gotLast[i], expData[i], (i == expLen - 1)); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        doReset();
        applyStimulus(8'hA1, 1'b0);
        applyStimulus(8'h04, 1'b0);
        waitReady(20, ok);
        popFrame(2);
        checkCount++;
        if (!ok || gotCnt !== 2 || gotData[0] !== 8'hA1 || gotData[1] !== 8'h42)
            begin failCount++; $display("[TB] FAIL b2b_head: got rdy=%b cnt=%0d %h %h expected 1 2 a1 42", ok, gotCnt, gotData[0], gotData[1]); end
        checkCount++;
        if (bus.tx_data !== 8'h30 || bus.tx_last !== 1'b1)
            begin failCount++; $display("[TB] FAIL b2b_last: got %h last=%b expected 30 last=1", bus.tx_data, bus.tx_last); end
        bus.tx_rd    = 1'b1;
        bus.rx_data  = 8'h77;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_rd    = 1'b0;
        bus.rx_valid = 1'b0;
        checkCount++;
        if (bus.tx_rdy !== 1'b0 || bus.overflow !== 1'b1 || bus.pay_len !== 8'd0)
            begin failCount++; $display("[TB] FAIL b2b_drop: got rdy=%b ovf=%b len=%0d expected 0 1 0", bus.tx_rdy, bus.overflow, bus.pay_len); end
        applyStimulus(8'h88, 1'b0);
        applyStimulus(8'h99, 1'b0);
        applyStimulus(8'h04, 1'b0);
        waitReady(20, ok);
        checkCount++;
        if (!ok) begin failCount++; $display("[TB] FAIL b2b_ready: got tx_rdy=0 expected 1"); end
        expData[0:3] = '{8'h88, 8'h42, 8'h30, 8'h99};
        expLen = 4;
        popFrame(10);
        checkCount++;
        if (gotCnt !== expLen) begin failCount++; $display("[TB] FAIL b2b_len: got %0d expected %0d", gotCnt, expLen); end
        for (int i = 0; i < gotCnt && i < expLen; i++) begin
            checkCount++;
            if (gotData[i] !== expData[i] || gotLast[i] !== (i == expLen - 1))
                begin failCount++; $display("[TB] FAIL b2b_byte%0d: got %h last=%b expected %h last=%b", i, gotData[i], gotLast[i], expData[i], (i == expLen - 1)); end
        end
        checkCount++;
        if (bus.overflow !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_sticky: got %b expected 1", bus.overflow); end
    endtask

    task automatic test_max_payload();
        bit ok;
        doReset();
        applyStimulus(8'h11, 1'b0);
        for (int k = 0; k < 252; k++) applyStimulus(8'(k + 8), 1'b0);
        checkCount++;
        if (bus.pay_len !== 8'd252 || bus.overflow !== 1'b0 || bus.tx_rdy !== 1'b0)
            begin failCount++; $display("[TB] FAIL max_commit: got len=%0d ovf=%b rdy=%b expected 252 0 0", bus.pay_len, bus.overflow, bus.tx_rdy); end
        applyStimulus(8'hEE, 1'b0);
        checkCount++;
        if (bus.overflow !== 1'b1) begin failCount++; $display("[TB] FAIL max_overflow: got %b expected 1", bus.overflow); end
        waitReady(20, ok);
        checkCount++;
        if (!ok) begin failCount++; $display("[TB] FAIL max_ready: got tx_rdy=0 expected 1"); end
        expData[0] = 8'h11;
        expData[1] = 8'h42;
        expData[2] = 8'h30;
        for (int k = 0; k < 252; k++) expData[k + 3] = 8'(k + 8);
        expLen = 255;
        popFrame(300);
        checkCount++;
        if (gotCnt !== expLen) begin failCount++; $display("[TB] FAIL max_len: got %0d expected %0d", gotCnt, expLen); end
        for (int i = 0; i < gotCnt && i < expLen; i++) begin
            checkCount++;
            if (gotData[i] !== expData[i] || gotLast[i] !== (i == expLen - 1))
                begin failCount++; $display("[TB] FAIL max_byte%0d: got %h last=%b expected %h last=%b", i, gotData[i], gotLast[i], expData[i], (i == expLen - 1)); end
        end
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_ferr  = 1'b0;
        bus.tx_rd    = 1'b0;
        doReset();
        test_reset();
        test_basic();
        test_zero_payload();
        test_ferr();
        test_reset_mid();
        test_stall();
        test_back_to_back();
        test_max_payload();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/wf_tx_frame_buffer.md
WF_TX_FRAME_BUFFER -- requirements
Module: wf_tx_frame_buffer

Interface
REQ-001 Parameter MAC_ADDR, 8'h42, station source address inserted into every frame header.
REQ-002 Parameter MAX_PAYLOAD, 252, maximum payload bytes per frame (header + payload <= 255).
REQ-003 Parameter TYPE_BYTE, 8'h30, frame type byte inserted after source address.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low (asserted when 0).
REQ-006 rx_data  in  8  byte from upstream UART receiver.
REQ-007 rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-008 rx_ferr  in  1  framing error accompanying rx_valid; byte discarded.
REQ-009 tx_rdy  out  1  committed frame available to downstream Manchester transmitter.
REQ-010 tx_data  out  8  current frame byte, valid while tx_rdy=1.
REQ-011 tx_last  out  1  high while tx_data is the final frame byte.
REQ-012 tx_rd  in  1  downstream pop; advances to next byte.
REQ-013 pay_len  out  8  payload bytes currently held.
REQ-014 overflow  out  1  sticky: a byte was dropped because the buffer was not accepting.

Function
REQ-015 States SHALL be IDLE, FILL, HOLD, SEND.
REQ-016 IDLE: first rx_valid byte (rx_ferr=0, rx_data!=8'h04) SHALL latch as destination, pay_len=0, -> FILL.
REQ-017 IDLE: 8'h04 SHALL be ignored; no frame produced.
REQ-018 FILL: rx_valid byte !=8'h04 SHALL write to RAM at pay_len, pay_len+1 next cycle.
REQ-019 FILL: 8'h04 (EOT) SHALL commit, including zero-payload frames, -> HOLD; EOT never stored.
REQ-020 FILL: write making pay_len==MAX_PAYLOAD SHALL auto-commit -> HOLD same edge.
REQ-021 rx_valid with rx_ferr=1 SHALL be discarded in every state without state change.
REQ-022 HOLD/SEND: valid bytes SHALL be dropped, setting overflow=1 until reset.
REQ-023 HOLD SHALL assert tx_rdy=1 next cycle, presenting byte 0, -> SEND.
REQ-024 Frame order: dest, MAC_ADDR, TYPE_BYTE, payload[0..pay_len-1].
REQ-025 tx_data SHALL be registered, show-ahead; tx_rd at cycle N presents next byte at N+1.
REQ-026 tx_rd while tx_rdy=0 SHALL be ignored.
REQ-027 tx_last=1 on final byte (TYPE_BYTE when pay_len=0); tx_rd there SHALL drop tx_rdy next cycle, clear pay_len, -> IDLE.
REQ-028 Read index SHALL be 8-bit, never wrap; header bytes not stored in RAM.
REQ-029 Back-to-back: byte arriving the cycle SEND->IDLE SHALL be dropped (overflow set); next cycle's byte starts a new frame.

Reset
REQ-030 rst=0 on a clock edge SHALL force IDLE, tx_rdy=0, tx_last=0, tx_data=8'h00, pay_len=0, overflow=0.
REQ-031 Reset mid-FILL or mid-SEND SHALL abandon the frame; RAM contents need not clear.
REQ-032 Outputs SHALL be valid from the first edge after rst returns to 1.

Structure
REQ-033 Package wf_pkg SHALL hold ASCII_EOT=8'h04, default TYPE_BYTE, MAX_PAYLOAD, state enum.
REQ-034 One sub-module wf_frame_ram: 256x8 simple dual-port, sync write, sync read (1-cycle).
REQ-035 Read address SHALL be issued one cycle early so registered tx_data meets REQ-025.

Verification
REQ-036 Bytes 44,19,E1,2F,4B,04 -> tx_rdy; pops yield 44,42,30,19,E1,2F,4B; tx_last on 4B only.
REQ-037 Bytes 66,04 -> frame 66,42,30; tx_last on 30; pay_len=0.
REQ-038 Dest 11 then 252 payload bytes, no EOT -> auto-commit, 255-byte frame, next byte sets overflow.
REQ-039 rx_ferr=1 on third byte of 44,19,E1,2F,04 -> frame 44,42,30,19,2F; overflow=0.
REQ-040 rst=0 after 44,19,E1 -> pay_len=0, tx_rdy=0; then 55,AA,04 -> frame 55,42,30,AA.
REQ-041 No tx_rd for 1000 cycles after commit -> tx_data/tx_rdy stable; later pops complete frame intact.
